regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 64 ++++++
 tb/tb_regfile_mp.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: dual-write, dual-read register file with per-register pending-producer (busy) tracking
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ra_addr,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data,
   output logic              ra_busy,
   output logic              rb_busy,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] wa0,
   input  logic [ADDR_W-1:0] wa1,
   input  logic [DATA_W-1:0] wd0,
   input  logic [DATA_W-1:0] wd1,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   input  logic              flush
);
   localparam int DEPTH = 2 ** ADDR_W;
   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic              w0_v, w1_v, ra_h0, ra_h1, rb_h0, rb_h1;
   assign w0_v  = we0 && wa0 != '0;
   assign w1_v  = we1 && wa1 != '0;
   assign ra_h0 = BYPASS != 0 && w0_v && wa0 == ra_addr;
   assign ra_h1 = BYPASS != 0 && w1_v && wa1 == ra_addr;
   assign rb_h0 = BYPASS != 0 && w0_v && wa0 == rb_addr;
   assign rb_h1 = BYPASS != 0 && w1_v && wa1 == rb_addr;
   // port 1 is applied after port 0 so it wins on a shared address; issue beats write, flush beats issue
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (w0_v) begin
         regs_d[wa0] = wd0;
         busy_d[wa0] = 1'b0;
      end
      if (w1_v) begin
         regs_d[wa1] = wd1;
         busy_d[wa1] = 1'b0;
      end
      if (iss_en && iss_addr != '0) busy_d[iss_addr] = 1'b1;
      if (flush) busy_d = '0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
         busy_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
         busy_q <= busy_d;
      end
   end
   assign ra_data = ra_h1 ? wd1 : ra_h0 ? wd0 : regs_q[ra_addr];
   assign rb_data = rb_h1 ? wd1 : rb_h0 ? wd0 : regs_q[rb_addr];
   assign ra_busy = busy_q[ra_addr] && !(ra_h0 || ra_h1);
   assign rb_busy = busy_q[rb_addr] && !(rb_h0 || rb_h1);
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: checks a forwarding and a non-forwarding regfile_mp against a behavioural model
module tb_regfile_mp;
   logic        clk = 0, rst = 1;
   logic [4:0]  ra_addr, rb_addr, wa0, wa1, iss_addr;
   logic        we0, we1, iss_en, flush;
   logic [31:0] wd0, wd1;
   logic [31:0] ra_data_b, rb_data_b, ra_data_n, rb_data_n;
   logic        ra_busy_b, rb_busy_b, ra_busy_n, rb_busy_n;
   int          checks = 0, errors = 0;
   logic [31:0] mem [32];
   bit          bz [32];

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_b (
      .clk(clk), .rst(rst), .ra_addr(ra_addr), .rb_addr(rb_addr),
      .ra_data(ra_data_b), .rb_data(rb_data_b), .ra_busy(ra_busy_b), .rb_busy(rb_busy_b),
      .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
      .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush));
   regfile_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_n (
      .clk(clk), .rst(rst), .ra_addr(ra_addr), .rb_addr(rb_addr),
      .ra_data(ra_data_n), .rb_data(rb_data_n), .ra_busy(ra_busy_n), .rb_busy(rb_busy_n),
      .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
      .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush));

   always #5 clk = ~clk;

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         mem[i] = '0;
         bz[i]  = 0;
      end
   endtask

   // register and busy state after one rising edge, derived from the write/issue/flush rules
   task automatic model_edge();
      bit wrote [32];
      if (rst) return;
      for (int i = 0; i < 32; i++) wrote[i] = 0;
      if (we0 && wa0 != 0) begin mem[wa0] = wd0; wrote[wa0] = 1; end
      if (we1 && wa1 != 0) begin mem[wa1] = wd1; wrote[wa1] = 1; end
      for (int i = 1; i < 32; i++)
         bz[i] = flush ? 0 : (iss_en && iss_addr == i) ? 1 : wrote[i] ? 0 : bz[i];
   endtask

   function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
      if (byp && we1 && wa1 != 0 && wa1 == a) return wd1;
      if (byp && we0 && wa0 != 0 && wa0 == a) return wd0;
      return a == 0 ? 32'h0 : mem[a];
   endfunction

   function automatic bit exp_busy(input logic [4:0] a, input bit byp);
      if (byp && ((we1 && wa1 != 0 && wa1 == a) || (we0 && wa0 != 0 && wa0 == a))) return 0;
      return a == 0 ? 0 : bz[a];
   endfunction

   task automatic idle();
      {we0, we1, iss_en, flush} = '0;
      {wa0, wa1, iss_addr} = '0;
      {wd0, wd1} = '0;
   endtask

   task automatic edge_step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      idle();
      ra_addr = 0;
      rb_addr = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
      model_clear();
      for (int i = 0; i < 32; i++) begin
         ra_addr = 5'(i);
         rb_addr = 5'(31 - i);
         #1;
         checks++;
         if ({ra_data_b, rb_data_b, ra_data_n, rb_data_n} !== '0) begin
            errors++;
            $display("FAIL reset_data addr %0d: got %h %h %h %h expected 0", i, ra_data_b, rb_data_b, ra_data_n, rb_data_n);
         end
         checks++;
         if ({ra_busy_b, rb_busy_b, ra_busy_n, rb_busy_n} !== 4'b0) begin
            errors++;
            $display("FAIL reset_busy addr %0d: got %b%b%b%b expected 0000", i, ra_busy_b, rb_busy_b, ra_busy_n, rb_busy_n);
         end
      end
   endtask

   task automatic test_bypass();
      idle();
      we0 = 1; wa0 = 5; wd0 = 32'hA5A5A5A5; ra_addr = 5;
      #1;
      checks++;
      if (ra_data_b !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_same_cycle: got %h expected a5a5a5a5", ra_data_b); end
      checks++;
      if (ra_data_n !== 32'h0) begin errors++; $display("FAIL nobypass_same_cycle: got %h expected 0", ra_data_n); end
      edge_step();
      idle();
      #1;
      checks++;
      if (ra_data_n !== 32'hA5A5A5A5) begin errors++; $display("FAIL nobypass_next_cycle: got %h expected a5a5a5a5", ra_data_n); end
   endtask

   task automatic test_same_addr();
      idle();
      we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 1; wd1 = 2; ra_addr = 7; rb_addr = 7;
      #1;
      checks++;
      if (ra_data_b !== 32'd2) begin errors++; $display("FAIL dual_write_bypass: got %h expected 2", ra_data_b); end
      edge_step();
      idle();
      #1;
      checks++;
      if (ra_data_b !== 32'd2 || rb_data_n !== 32'd2) begin
         errors++;
         $display("FAIL dual_write_stored: got %h %h expected 2", ra_data_b, rb_data_n);
      end
   endtask

   task automatic test_reg0();
      idle();
      we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF; we1 = 1; wa1 = 0; wd1 = 32'hFFFFFFFF;
      iss_en = 1; iss_addr = 0; ra_addr = 0; rb_addr = 0;
      #1;
      checks++;
      if (ra_data_b !== 32'h0 || ra_busy_b !== 1'b0) begin
         errors++;
         $display("FAIL reg0_same_cycle: got %h/%b expected 0/0", ra_data_b, ra_busy_b);
      end
      edge_step();
      idle();
      #1;
      checks++;
      if ({ra_data_b, ra_data_n, ra_busy_b, ra_busy_n} !== '0) begin
         errors++;
         $display("FAIL reg0_after: got %h %h %b %b expected 0", ra_data_b, ra_data_n, ra_busy_b, ra_busy_n);
      end
   endtask

   task automatic test_busy();
      idle();
      ra_addr = 3; rb_addr = 4;
      iss_en = 1; iss_addr = 3;
      edge_step();
      idle();
      #1;
      checks++;
      if (ra_busy_b !== 1'b1 || ra_busy_n !== 1'b1) begin errors++; $display("FAIL busy_issue: got %b%b expected 11", ra_busy_b, ra_busy_n); end
      we0 = 1; wa0 = 3; wd0 = 32'h33; iss_en = 1; iss_addr = 3;
      #1;
      checks++;
      if (ra_busy_b !== 1'b0 || ra_busy_n !== 1'b1) begin errors++; $display("FAIL busy_forward_mask: got %b%b expected 01", ra_busy_b, ra_busy_n); end
      edge_step();
      idle();
      #1;
      checks++;
      if (ra_busy_n !== 1'b1) begin errors++; $display("FAIL busy_write_and_issue: got %b expected 1", ra_busy_n); end
      we1 = 1; wa1 = 3; wd1 = 32'h34;
      edge_step();
      idle();
      #1;
      checks++;
      if (ra_busy_n !== 1'b0 || ra_data_n !== 32'h34) begin errors++; $display("FAIL busy_write_clears: got %b/%h expected 0/34", ra_busy_n, ra_data_n); end
      iss_en = 1; iss_addr = 4;
      edge_step();
      iss_en = 1; iss_addr = 3; flush = 1; we0 = 1; wa0 = 3; wd0 = 32'h35;
      edge_step();
      idle();
      #1;
      checks++;
      if ({ra_busy_n, rb_busy_n} !== 2'b00 || ra_data_n !== 32'h35) begin
         errors++;
         $display("FAIL flush_over_issue: got %b%b/%h expected 00/35", ra_busy_n, rb_busy_n, ra_data_n);
      end
   endtask

   task automatic test_reset_mid();
      idle();
      ra_addr = 9;
      we0 = 1; wa0 = 9; wd0 = 32'h12;
      edge_step();
      idle();
      iss_en = 1; iss_addr = 9;
      edge_step();
      idle();
      #1;
      checks++;
      if (ra_data_n !== 32'h12 || ra_busy_n !== 1'b1) begin errors++; $display("FAIL pre_reset_state: got %h/%b expected 12/1", ra_data_n, ra_busy_n); end
      rst = 1;
      model_clear();
      #1;
      checks++;
      if ({ra_data_b, ra_data_n, ra_busy_b, ra_busy_n} !== '0) begin
         errors++;
         $display("FAIL async_reset: got %h %h %b %b expected 0", ra_data_b, ra_data_n, ra_busy_b, ra_busy_n);
      end
      we0 = 1; wa0 = 9; wd0 = 32'h77;
      #1;
      checks++;
      if (ra_data_b !== 32'h77 || ra_data_n !== 32'h0) begin errors++; $display("FAIL reset_forward: got %h %h expected 77 0", ra_data_b, ra_data_n); end
      idle();
      #1;
      rst = 0;
      we1 = 1; wa1 = 9; wd1 = 32'h99;
      edge_step();
      idle();
      #1;
      checks++;
      if (ra_data_n !== 32'h99 || ra_busy_n !== 1'b0) begin errors++; $display("FAIL post_reset_write: got %h/%b expected 99/0", ra_data_n, ra_busy_n); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
         wa0 = 5'($urandom_range(0, 7)); wa1 = 5'($urandom_range(0, 7));
         wd0 = $urandom; wd1 = $urandom;
         iss_en = 1'($urandom_range(0, 1)); iss_addr = 5'($urandom_range(0, 7));
         flush = $urandom_range(0, 15) == 0;
         ra_addr = 5'($urandom_range(0, 7));
         rb_addr = n[0] ? 5'($urandom) : 5'($urandom_range(0, 7));
         #1;
         checks++;
         if ({ra_busy_b, ra_data_b} !== {exp_busy(ra_addr, 1), exp_data(ra_addr, 1)}) begin
            errors++;
            $display("FAIL rand_a_bypass @%0d addr %0d: got %b/%h expected %b/%h", n, ra_addr, ra_busy_b, ra_data_b, exp_busy(ra_addr, 1), exp_data(ra_addr, 1));
         end
         checks++;
         if ({rb_busy_b, rb_data_b} !== {exp_busy(rb_addr, 1), exp_data(rb_addr, 1)}) begin
            errors++;
            $display("FAIL rand_b_bypass @%0d addr %0d: got %b/%h expected %b/%h", n, rb_addr, rb_busy_b, rb_data_b, exp_busy(rb_addr, 1), exp_data(rb_addr, 1));
         end
         checks++;
         if ({ra_busy_n, ra_data_n} !== {exp_busy(ra_addr, 0), exp_data(ra_addr, 0)}) begin
            errors++;
            $display("FAIL rand_a_stored @%0d addr %0d: got %b/%h expected %b/%h", n, ra_addr, ra_busy_n, ra_data_n, exp_busy(ra_addr, 0), exp_data(ra_addr, 0));
         end
         checks++;
         if ({rb_busy_n, rb_data_n} !== {exp_busy(rb_addr, 0), exp_data(rb_addr, 0)}) begin
            errors++;
            $display("FAIL rand_b_stored @%0d addr %0d: got %b/%h expected %b/%h", n, rb_addr, rb_busy_n, rb_data_n, exp_busy(rb_addr, 0), exp_data(rb_addr, 0));
         end
         edge_step();
      end
      idle();
   endtask

   initial begin
      model_clear();
      test_reset();
      test_bypass();
      test_same_addr();
      test_reg0();
      test_busy();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
